// File: rtl/cpu_control_sequencer_if.sv
// Fetch-to-sequencer handshake plus the decoded control bundle for the datapath.
interface cpu_control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;

    logic             RegWrite;
    logic             ImmSel;
    logic             ALUSrc;
    logic             CompEnbl;
    logic             ShiftAmntSel;
    logic             ShiftEnbl;
    logic             ShortBr;
    logic             LongBr;
    logic             MemRead;
    logic             MemWrite;
    logic             BranchReg;
    logic [1:0]       ALUOp;
    logic [1:0]       RegDst;
    logic [1:0]       ShiftType;
    logic [1:0]       BranchType;
    logic [1:0]       JumpType;
    logic [1:0]       MemToReg;

    logic             illegal;
    logic [CNT_W-1:0] issued;

    // Fetch side: drives instructions, watches ready and the control bundle.
    modport master (
        output instr, instr_valid,
        input  instr_ready,
        input  RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
        input  ShortBr, LongBr, MemRead, MemWrite, BranchReg,
        input  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
        input  illegal, issued
    );

    // Sequencer side.
    modport slave (
        input  instr, instr_valid,
        output instr_ready,
        output RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
        output ShortBr, LongBr, MemRead, MemWrite, BranchReg,
        output ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
        output illegal, issued
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Registered decode/sequencing of miniRISC instructions into datapath controls,
// with bubble insertion for loads and control transfers.
module cpu_control_sequencer #(
    parameter int CNT_W     = 16,
    parameter int LOAD_WAIT = 1     // 1..3 cycles of MemRead hold before write-back
) (
    input  logic clk,
    input  logic rst,
    cpu_control_sequencer_if.slave bus
);

    typedef struct packed {
        logic       RegWrite;
        logic       ImmSel;
        logic       ALUSrc;
        logic       CompEnbl;
        logic       ShiftAmntSel;
        logic       ShiftEnbl;
        logic       ShortBr;
        logic       LongBr;
        logic       MemRead;
        logic       MemWrite;
        logic       BranchReg;
        logic [1:0] ALUOp;
        logic [1:0] RegDst;
        logic [1:0] ShiftType;
        logic [1:0] BranchType;
        logic [1:0] JumpType;
        logic [1:0] MemToReg;
    } ctrl_t;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ISSUE       = 2'd1;
    localparam logic [1:0] LOAD_WAIT_S = 2'd2;
    localparam logic [1:0] FLUSH       = 2'd3;

    logic [1:0]       state;
    ctrl_t            ctrlQ;
    logic             readyQ;
    logic             illegalQ;
    logic [CNT_W-1:0] issuedQ;
    logic [1:0]       waitCnt;
    logic             pendLoad;
    logic             pendBranch;

    ctrl_t            dec;
    logic             decLegal;
    logic             decLoad;
    logic             decBranch;

    logic [5:0]       op;
    logic [4:0]       funct;
    logic             xfer;

    assign op    = bus.instr[31:26];
    assign funct = bus.instr[4:0];
    assign xfer  = bus.instr_valid & readyQ;

    // Combinational decode of the word on the bus; only used at an accepting edge.
    always_comb begin
        dec       = '0;
        decLegal  = 1'b1;
        decLoad   = 1'b0;
        decBranch = 1'b0;
        case (op)
            6'd0: begin
                dec.RegWrite = 1'b1;
                case (funct)
                    5'd0: dec.ALUOp = 2'b01;
                    5'd1: begin dec.ALUOp = 2'b01; dec.CompEnbl = 1'b1; end
                    5'd2: dec.ALUOp = 2'b10;
                    5'd3: dec.ALUOp = 2'b11;
                    5'd4, 5'd5, 5'd6: begin
                        dec.ShiftEnbl    = 1'b1;
                        dec.ShiftAmntSel = 1'b1;
                        dec.ShiftType    = (funct == 5'd5) ? 2'b01 :
                                           (funct == 5'd6) ? 2'b10 : 2'b00;
                    end
                    5'd7, 5'd8, 5'd9: begin
                        dec.ShiftEnbl    = 1'b1;
                        dec.ShiftType    = (funct == 5'd8) ? 2'b01 :
                                           (funct == 5'd9) ? 2'b10 : 2'b00;
                    end
                    default: decLegal = 1'b0;
                endcase
            end
            6'd1: begin
                dec.RegWrite = 1'b1; dec.ALUSrc = 1'b1; dec.ALUOp = 2'b01;
            end
            6'd2: begin
                dec.RegWrite = 1'b1; dec.ALUSrc = 1'b1; dec.ALUOp = 2'b01;
                dec.CompEnbl = 1'b1;
            end
            6'd3: begin
                // Write-back is held off until the last load-wait cycle.
                dec.ALUSrc   = 1'b1; dec.ALUOp = 2'b01;
                dec.MemRead  = 1'b1; dec.MemToReg = 2'b01;
                decLoad      = 1'b1;
            end
            6'd4: begin
                dec.ALUSrc   = 1'b1; dec.ImmSel = 1'b1; dec.ALUOp = 2'b01;
                dec.MemWrite = 1'b1;
            end
            6'd5: begin
                dec.BranchReg  = 1'b1; dec.ShortBr = 1'b1;
                dec.BranchType = 2'b11; dec.JumpType = 2'b11;
                decBranch      = 1'b1;
            end
            6'd6: begin
                dec.ShortBr    = 1'b1;
                dec.BranchType = funct[1:0];
                dec.JumpType   = 2'b01;
                decBranch      = 1'b1;
                decLegal       = (funct <= 5'd2);
            end
            6'd7: begin
                dec.LongBr     = 1'b1;
                dec.JumpType   = 2'b10;
                dec.BranchType = funct[1:0];
                decBranch      = 1'b1;
                decLegal       = (funct <= 5'd3);
                // bl links: write return address into the link register.
                if (funct == 5'd1) begin
                    dec.RegWrite = 1'b1; dec.RegDst = 2'b10; dec.MemToReg = 2'b10;
                end
            end
            default: decLegal = 1'b0;
        endcase
    end

    // Sequencer state, registered control bundle, ready, illegal pulse and issue count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ctrlQ      <= '0;
            readyQ     <= 1'b0;
            illegalQ   <= 1'b0;
            issuedQ    <= '0;
            waitCnt    <= '0;
            pendLoad   <= 1'b0;
            pendBranch <= 1'b0;
        end else begin
            illegalQ <= 1'b0;
            ctrlQ    <= '0;
            case (state)
                IDLE: begin
                    readyQ <= 1'b1;
                    if (xfer) begin
                        // Either outcome occupies one slot, so ready drops for a cycle.
                        readyQ <= 1'b0;
                        if (decLegal) begin
                            ctrlQ      <= dec;
                            state      <= ISSUE;
                            issuedQ    <= issuedQ + 1'b1;
                            pendLoad   <= decLoad;
                            pendBranch <= decBranch;
                        end else begin
                            illegalQ <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (pendLoad) begin
                        state            <= LOAD_WAIT_S;
                        waitCnt          <= 2'(LOAD_WAIT);
                        ctrlQ.MemRead    <= 1'b1;
                        ctrlQ.MemToReg   <= 2'b01;
                        ctrlQ.RegWrite   <= (LOAD_WAIT == 1);
                        readyQ           <= 1'b0;
                    end else if (pendBranch) begin
                        state  <= FLUSH;
                        readyQ <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        readyQ <= 1'b1;
                    end
                end
                LOAD_WAIT_S: begin
                    if (waitCnt == 2'd1) begin
                        state  <= IDLE;
                        readyQ <= 1'b1;
                    end else begin
                        waitCnt          <= waitCnt - 2'd1;
                        ctrlQ.MemRead    <= 1'b1;
                        ctrlQ.MemToReg   <= 2'b01;
                        ctrlQ.RegWrite   <= (waitCnt == 2'd2);
                        readyQ           <= 1'b0;
                    end
                end
                default: begin   // FLUSH
                    state  <= IDLE;
                    readyQ <= 1'b1;
                end
            endcase
        end
    end

    assign bus.instr_ready  = readyQ;
    assign bus.illegal      = illegalQ;
    assign bus.issued       = issuedQ;
    assign bus.RegWrite     = ctrlQ.RegWrite;
    assign bus.ImmSel       = ctrlQ.ImmSel;
    assign bus.ALUSrc       = ctrlQ.ALUSrc;
    assign bus.CompEnbl     = ctrlQ.CompEnbl;
    assign bus.ShiftAmntSel = ctrlQ.ShiftAmntSel;
    assign bus.ShiftEnbl    = ctrlQ.ShiftEnbl;
    assign bus.ShortBr      = ctrlQ.ShortBr;
    assign bus.LongBr       = ctrlQ.LongBr;
    assign bus.MemRead      = ctrlQ.MemRead;
    assign bus.MemWrite     = ctrlQ.MemWrite;
    assign bus.BranchReg    = ctrlQ.BranchReg;
    assign bus.ALUOp        = ctrlQ.ALUOp;
    assign bus.RegDst       = ctrlQ.RegDst;
    assign bus.ShiftType    = ctrlQ.ShiftType;
    assign bus.BranchType   = ctrlQ.BranchType;
    assign bus.JumpType     = ctrlQ.JumpType;
    assign bus.MemToReg     = ctrlQ.MemToReg;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer (CNT_W=4 so wrap is reachable, LOAD_WAIT=1).
module tb_cpu_control_sequencer;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       RegWrite;
        logic       ImmSel;
        logic       ALUSrc;
        logic       CompEnbl;
        logic       ShiftAmntSel;
        logic       ShiftEnbl;
        logic       ShortBr;
        logic       LongBr;
        logic       MemRead;
        logic       MemWrite;
        logic       BranchReg;
        logic [1:0] ALUOp;
        logic [1:0] RegDst;
        logic [1:0] ShiftType;
        logic [1:0] BranchType;
        logic [1:0] JumpType;
        logic [1:0] MemToReg;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ctrl_t e;

    cpu_control_sequencer_if #(.CNT_W(CNT_W)) ifc ();

    cpu_control_sequencer #(.CNT_W(CNT_W), .LOAD_WAIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t obs();
        ctrl_t o;
        o.RegWrite = ifc.RegWrite;   o.ImmSel = ifc.ImmSel;     o.ALUSrc = ifc.ALUSrc;
        o.CompEnbl = ifc.CompEnbl;   o.ShiftAmntSel = ifc.ShiftAmntSel;
        o.ShiftEnbl = ifc.ShiftEnbl; o.ShortBr = ifc.ShortBr;   o.LongBr = ifc.LongBr;
        o.MemRead = ifc.MemRead;     o.MemWrite = ifc.MemWrite; o.BranchReg = ifc.BranchReg;
        o.ALUOp = ifc.ALUOp;         o.RegDst = ifc.RegDst;     o.ShiftType = ifc.ShiftType;
        o.BranchType = ifc.BranchType; o.JumpType = ifc.JumpType; o.MemToReg = ifc.MemToReg;
        return o;
    endfunction

    task automatic chkC(input string tag, input ctrl_t exp);
        ctrl_t o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic chkV(input string tag, input logic [31:0] o, input logic [31:0] exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] fn);
        ifc.instr       = {op, 21'h0, fn};
        ifc.instr_valid = 1'b1;
    endtask

    initial begin
        ifc.instr       = '0;
        ifc.instr_valid = 1'b0;

        // Reset state
        step(); step();
        chkV("rst_ready", ifc.instr_ready, 0);
        chkV("rst_illegal", ifc.illegal, 0);
        chkV("rst_issued", ifc.issued, 0);
        chkC("rst_ctrl", '0);
        rst = 1'b0;
        step();
        chkV("ready_after_rst", ifc.instr_ready, 1);
        chkC("idle_bubble", '0);

        // addi
        send(6'd1, 5'd0);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.RegWrite = 1; e.ALUSrc = 1; e.ALUOp = 2'b01;
        chkC("addi_issue", e);
        chkV("addi_issued", ifc.issued, 1);
        chkV("addi_ready", ifc.instr_ready, 0);
        step();
        chkC("addi_after", '0);
        chkV("addi_after_ready", ifc.instr_ready, 1);

        // comp then compi with valid held high
        send(6'd0, 5'd1);
        step();
        e = '0; e.RegWrite = 1; e.ALUOp = 2'b01; e.CompEnbl = 1;
        chkC("comp_issue", e);
        send(6'd2, 5'd0);
        step();
        chkC("comp_gap", '0);
        chkV("comp_gap_ready", ifc.instr_ready, 1);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.RegWrite = 1; e.ALUSrc = 1; e.ALUOp = 2'b01; e.CompEnbl = 1;
        chkC("compi_issue", e);
        chkV("compi_issued", ifc.issued, 3);
        step();

        // lw with one wait cycle
        send(6'd3, 5'd0);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.ALUSrc = 1; e.ALUOp = 2'b01; e.MemRead = 1; e.MemToReg = 2'b01;
        chkC("lw_issue", e);
        chkV("lw_issue_ready", ifc.instr_ready, 0);
        step();
        e = '0; e.MemRead = 1; e.MemToReg = 2'b01; e.RegWrite = 1;
        chkC("lw_wait", e);
        chkV("lw_wait_ready", ifc.instr_ready, 0);
        step();
        chkC("lw_done", '0);
        chkV("lw_done_ready", ifc.instr_ready, 1);

        // br then addi: one flush bubble, addi issues 3 cycles later
        send(6'd5, 5'd0);
        step();
        e = '0; e.BranchReg = 1; e.ShortBr = 1; e.BranchType = 2'b11; e.JumpType = 2'b11;
        chkC("br_issue", e);
        send(6'd1, 5'd0);
        step();
        chkC("br_flush", '0);
        chkV("br_flush_ready", ifc.instr_ready, 0);
        step();
        chkC("br_idle", '0);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.RegWrite = 1; e.ALUSrc = 1; e.ALUOp = 2'b01;
        chkC("br_addi_issue", e);
        chkV("br_addi_issued", ifc.issued, 6);
        step();

        // illegal op 63, then add
        send(6'd63, 5'd0);
        step();
        chkV("ill_pulse", ifc.illegal, 1);
        chkC("ill_ctrl", '0);
        chkV("ill_issued", ifc.issued, 6);
        send(6'd0, 5'd0);
        step();
        chkV("ill_pulse_end", ifc.illegal, 0);
        chkV("ill_ready", ifc.instr_ready, 1);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.RegWrite = 1; e.ALUOp = 2'b01;
        chkC("add_issue", e);
        chkV("add_issued", ifc.issued, 7);
        step();

        // shrav
        send(6'd0, 5'd9);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.RegWrite = 1; e.ShiftEnbl = 1; e.ShiftType = 2'b10;
        chkC("shrav_issue", e);
        step();

        // bl
        send(6'd7, 5'd1);
        step();
        ifc.instr_valid = 1'b0;
        e = '0; e.LongBr = 1; e.JumpType = 2'b10; e.BranchType = 2'b01;
        e.RegWrite = 1; e.RegDst = 2'b10; e.MemToReg = 2'b10;
        chkC("bl_issue", e);
        chkV("bl_issued", ifc.issued, 9);
        step();
        chkC("bl_flush", '0);
        step();

        // Reset cuts a load before its write-back cycle
        send(6'd3, 5'd0);
        step();
        ifc.instr_valid = 1'b0;
        chkV("lw2_issued", ifc.issued, 10);
        rst = 1'b1;
        step();
        chkV("abort_regwrite", ifc.RegWrite, 0);
        chkC("abort_ctrl", '0);
        chkV("abort_issued", ifc.issued, 0);
        rst = 1'b0;
        step();
        chkV("abort_ready", ifc.instr_ready, 1);

        // 16 legal issues wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            send(6'd1, 5'd0);
            step();
            ifc.instr_valid = 1'b0;
            if (i == 14) chkV("cnt_15", ifc.issued, 15);
            step();
        end
        chkV("cnt_wrap", ifc.issued, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

- Registered, handshaked control unit for the miniRISC datapath.
- Accepts 32-bit instruction words from the fetch stage and decodes them into the control bundle that `CPU_TOP_MODULE` takes as inputs.
- Inserts the bubble cycles the single-cycle datapath needs around loads and control transfers, and flags illegal encodings.
- Replaces hand-driven control stimulus; sits between instruction fetch and the datapath top.

## Interface
- `CNT_W`, 16: width of issued-instruction counter.
- `LOAD_WAIT`, 1: extra cycles a load holds `MemRead` before write-back (1..3).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `instr`  in  32  instruction word; opcode `instr[31:26]`, funct `instr[4:0]`.
- `instr_valid`  in  1  `instr` valid this cycle.
- `instr_ready`  out  1  sequencer can accept; transfer = `instr_valid & instr_ready` at rising edge.
- `RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg`  out  1 each  datapath controls.
- `ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg`  out  2 each  datapath controls.
- `illegal`  out  1  one-cycle pulse: rejected encoding.
- `issued`  out  CNT_W  count of legally issued instructions, wraps.

## Operation
- States: IDLE, ISSUE, LOAD_WAIT_S, FLUSH.
- IDLE:
  - `instr_ready`=1.
  - On a transfer: decode into the output registers, go to ISSUE.
  - Otherwise all controls 0 (bubble).
- Decode, by opcode; any field not listed is 0:
  - op 0, R-type, `ALUSrc`=0:
    - funct 0 add: `ALUOp`=01.
    - funct 1 comp: `ALUOp`=01, `CompEnbl`=1.
    - funct 2 and: `ALUOp`=10.
    - funct 3 xor: `ALUOp`=11.
    - funct 4/5/6 shll/shrl/shra: `ShiftEnbl`=1, `ShiftAmntSel`=1, `ShiftType`=00/01/10.
    - funct 7/8/9 shllv/shrlv/shrav: same as 4/5/6 with `ShiftAmntSel`=0.
    - All R-type set `RegWrite`=1.
  - op 1 addi: `RegWrite`=1, `ALUSrc`=1, `ALUOp`=01.
  - op 2 compi: same as addi, plus `CompEnbl`=1.
  - op 3 lw: `ALUSrc`=1, `ALUOp`=01, `MemRead`=1, `MemToReg`=01; `RegWrite` is deferred (see ISSUE).
  - op 4 sw: `ALUSrc`=1, `ImmSel`=1, `ALUOp`=01, `MemWrite`=1.
  - op 5 br: `BranchReg`=1, `ShortBr`=1, `BranchType`=11, `JumpType`=11.
  - op 6 bltz/bz/bnz (funct 0/1/2): `ShortBr`=1, `BranchType`=funct[1:0], `JumpType`=01.
  - op 7 b/bl/bcy/bncy (funct 0..3): `LongBr`=1, `JumpType`=10, `BranchType`=funct[1:0].
    - bl additionally sets `RegWrite`=1, `RegDst`=10, `MemToReg`=10.
  - Any other op, or funct out of range: illegal.
- ISSUE: controls presented for exactly one cycle; `instr_ready`=0. Next state:
  - lw → LOAD_WAIT_S with wait count = `LOAD_WAIT`.
  - Any branch (ops 5–7) → FLUSH.
  - Otherwise → IDLE.
- LOAD_WAIT_S: `MemRead`=1 and `MemToReg`=01 held each cycle; `instr_ready`=0.
  - Last wait cycle: `RegWrite`=1, then → IDLE.
- FLUSH: one bubble cycle, all controls 0, `instr_ready`=0, then → IDLE.
- Illegal encoding:
  - Accepted, but the sequencer stays in IDLE with a bubble.
  - `illegal`=1 for the cycle following acceptance.
  - `issued` is not incremented.
- `issued` increments once per legal instruction, in its ISSUE cycle; it wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (`rst` high at a clock edge):
  - Next cycle: all control outputs 0, `illegal`=0, `issued`=0, state IDLE, `instr_ready`=0.
  - `instr_ready`=1 from the first cycle after `rst` deasserts.
  - Reset mid-load or mid-flush aborts the instruction: no `RegWrite` pulse, no count change.
- Latency: controls appear in the cycle after the accepting edge (1 cycle).
- Throughput:
  - ALU, store and illegal instructions: one per 2 cycles (ISSUE, then IDLE).
  - Load: 2+`LOAD_WAIT` cycles.
  - Branch: 3 cycles.
- `instr_ready` is a registered function of state only; it does not depend on `instr_valid`.
- `instr_valid` low in IDLE: outputs stay 0 indefinitely.
- `instr` is sampled only at the accepting edge; later changes are ignored.

## Test plan
- Reset released; transfer addi (op 1) → next cycle `RegWrite`=1, `ALUSrc`=1, `ALUOp`=01, all other controls 0, `issued`=1; following cycle all 0 and `instr_ready`=1.
- Transfer comp (op 0, funct 1), then compi (op 2) back-to-back with `instr_valid` held high → each issue cycle has `CompEnbl`=1; `ALUSrc`=0 then 1; issue cycles are exactly 2 cycles apart.
- lw with `LOAD_WAIT`=1 → ISSUE: `MemRead`=1, `RegWrite`=0; next cycle: `MemRead`=1, `RegWrite`=1, `MemToReg`=01; `instr_ready`=0 across both cycles.
- br (op 5) then addi → br cycle: `BranchReg`=1, `ShortBr`=1, `BranchType`=11, `JumpType`=11; then one all-zero cycle; addi issues 3 cycles after br.
- op 63 → `illegal`=1 for one cycle, all controls 0, `issued` unchanged; a following valid add issues normally.
- `rst` asserted during LOAD_WAIT_S → no `RegWrite` pulse; outputs 0 and `issued`=0 from the next cycle. Separately, with `CNT_W`=4, 16 legal issues return `issued` to 0.
